// File: rtl/ib32bit_fetch_ctrl_if.sv
// Instruction-memory and decode handshakes of the 32-bit instruction block fetch controller.
// The master modport is the fetch controller; the slave modport is the memory/decode side.
interface ib32bit_fetch_ctrl_if #(
  parameter int AWIDTH = 6,
  parameter int RWIDTH = 32
);
  logic              imem_req;
  logic [AWIDTH-1:0] imem_addr;
  logic              imem_ack;
  logic [RWIDTH-1:0] imem_rdata;
  logic              inst_valid;
  logic [RWIDTH-1:0] inst_data;
  logic [AWIDTH-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_ack, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_ack, imem_rdata, inst_ready
  );
endinterface

// File: rtl/ib32bit_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues imem req/ack reads and presents fetched words to decode.
// Handles redirect (highest priority), halt/restart and a sticky memory-timeout error.
module ib32bit_fetch_ctrl #(
  parameter int                 AWIDTH   = 6,
  parameter int                 RWIDTH   = 32,
  parameter logic [AWIDTH-1:0]  RESET_PC = '0,
  parameter int                 TIMEOUT  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt,
  input  logic [AWIDTH-1:0]     inc,
  input  logic                  redirect,
  input  logic [AWIDTH-1:0]     redirect_addr,
  ib32bit_fetch_ctrl_if.master  bus,
  output logic [AWIDTH-1:0]     pc,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  // Last wait count before giving up; a REQ lasts at most TIMEOUT cycles.
  localparam logic [7:0] WLAST = 8'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [AWIDTH-1:0] pc_q, pc_nx;
  logic [AWIDTH-1:0] ipc_q, ipc_nx;
  logic [RWIDTH-1:0] data_q, data_nx;
  logic              valid_q, valid_nx;
  logic              err_q, err_nx;
  logic              busy_q;
  logic [7:0]        wcnt_q, wcnt_nx;

  function automatic logic [AWIDTH-1:0] pc_step(input logic [AWIDTH-1:0] cur,
                                                input logic [AWIDTH-1:0] step);
    return cur + step;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    ipc_nx   = ipc_q;
    data_nx  = data_q;
    valid_nx = valid_q;
    err_nx   = err_q;
    wcnt_nx  = wcnt_q;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          err_nx   = 1'b0;
          wcnt_nx  = '0;
          state_nx = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect) begin
          pc_nx    = redirect_addr;
          valid_nx = 1'b0;
          wcnt_nx  = '0;
          state_nx = S_REQ;
        end else if (bus.imem_ack) begin
          data_nx  = bus.imem_rdata;
          ipc_nx   = pc_q;
          valid_nx = 1'b1;
          state_nx = S_HOLD;
        end else if (wcnt_q >= WLAST) begin
          err_nx   = 1'b1;
          wcnt_nx  = '0;
          state_nx = S_IDLE;
        end else begin
          wcnt_nx  = wcnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        // A redirect drops the held word even if decode is ready this cycle.
        if (redirect) begin
          pc_nx    = redirect_addr;
          valid_nx = 1'b0;
          wcnt_nx  = '0;
          state_nx = S_REQ;
        end else if (bus.inst_ready) begin
          pc_nx    = pc_step(pc_q, inc);
          valid_nx = 1'b0;
          wcnt_nx  = '0;
          state_nx = halt ? S_IDLE : S_REQ;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      ipc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      pc_q    <= pc_nx;
      ipc_q   <= ipc_nx;
      data_q  <= data_nx;
      valid_q <= valid_nx;
      err_q   <= err_nx;
      busy_q  <= (state_nx != S_IDLE);
      wcnt_q  <= wcnt_nx;
    end
  end

  assign bus.imem_req   = (state == S_REQ);
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = valid_q;
  assign bus.inst_data  = data_q;
  assign bus.inst_pc    = ipc_q;
  assign pc             = pc_q;
  assign busy           = busy_q;
  assign err            = err_q;

endmodule

// File: tb/tb_ib32bit_fetch_ctrl.sv
// Directed bench for ib32bit_fetch_ctrl: memory returns 0x1000_0000+addr with a same-cycle ack.
module tb_ib32bit_fetch_ctrl;
  localparam int AW = 6;
  localparam int RW = 32;

  logic          clk = 1'b0;
  logic          rst, start, halt, redirect, mem_en, inst_ready;
  logic [AW-1:0] inc, redirect_addr, pc;
  logic          busy, err;
  int            n_checks = 0;
  int            n_fail   = 0;

  ib32bit_fetch_ctrl_if #(.AWIDTH(AW), .RWIDTH(RW)) bus ();

  assign bus.imem_ack   = mem_en & bus.imem_req;
  assign bus.imem_rdata = 32'h1000_0000 + 32'(bus.imem_addr);
  assign bus.inst_ready = inst_ready;

  ib32bit_fetch_ctrl #(.AWIDTH(AW), .RWIDTH(RW), .RESET_PC('0), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .inc(inc),
    .redirect(redirect), .redirect_addr(redirect_addr), .bus(bus),
    .pc(pc), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_addr = '0;
    inc = 6'd1; inst_ready = 1'b1; mem_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Leaves the controller in REQ with pc=addr at a falling edge.
  task automatic goto_pc(input logic [AW-1:0] addr, input logic ack_en);
    apply_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; redirect = 1'b1; redirect_addr = addr;
    @(negedge clk);
    redirect = 1'b0; mem_en = ack_en;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (bus.imem_req !== 1'b0)   begin n_fail++; $display("FAIL rst_req: got %b expected 0", bus.imem_req); end
    n_checks++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", bus.inst_valid); end
    n_checks++; if (busy !== 1'b0)           begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (err !== 1'b0)            begin n_fail++; $display("FAIL rst_err: got %b expected 0", err); end
    n_checks++; if (pc !== 6'd0)             begin n_fail++; $display("FAIL rst_pc: got %0d expected 0", pc); end
    n_checks++; if (bus.inst_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h expected 0", bus.inst_data); end
    n_checks++; if (bus.inst_pc !== 6'd0)    begin n_fail++; $display("FAIL rst_ipc: got %0d expected 0", bus.inst_pc); end
  endtask

  task automatic test_stream();
    apply_reset();
    mem_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 6'(k) || bus.inst_valid !== 1'b0) begin
        n_fail++; $display("FAIL stream_req[%0d]: req=%b addr=%0d valid=%b expected 1 %0d 0", k, bus.imem_req, bus.imem_addr, bus.inst_valid, k);
      end
      @(negedge clk);
      n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 6'(k)) begin
        n_fail++; $display("FAIL stream_valid[%0d]: valid=%b pc=%0d expected 1 %0d", k, bus.inst_valid, bus.inst_pc, k);
      end
      n_checks++; if (bus.inst_data !== 32'h1000_0000 + k) begin
        n_fail++; $display("FAIL stream_data[%0d]: got %h expected %h", k, bus.inst_data, 32'h1000_0000 + k);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp;
    goto_pc(6'd62, 1'b1);
    for (int k = 0; k < 3; k++) begin
      exp = 6'(62 + k);
      n_checks++; if (bus.imem_addr !== exp) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", k, bus.imem_addr, exp); end
      @(negedge clk);
      n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp) begin
        n_fail++; $display("FAIL wrap_ipc[%0d]: valid=%b pc=%0d expected 1 %0d", k, bus.inst_valid, bus.inst_pc, exp);
      end
      @(negedge clk);
    end
    n_checks++; if (pc !== 6'd1) begin n_fail++; $display("FAIL wrap_pc: got %0d expected 1", pc); end
  endtask

  task automatic test_stall();
    goto_pc(6'd10, 1'b1);
    inc = 6'd3; inst_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 6'd10 || bus.inst_data !== 32'h1000_000A) begin
        n_fail++; $display("FAIL stall_hold[%0d]: valid=%b pc=%0d data=%h expected 1 10 1000000a", k, bus.inst_valid, bus.inst_pc, bus.inst_data);
      end
      n_checks++; if (pc !== 6'd10 || bus.imem_req !== 1'b0) begin
        n_fail++; $display("FAIL stall_pc[%0d]: pc=%0d req=%b expected 10 0", k, pc, bus.imem_req);
      end
      @(negedge clk);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (pc !== 6'd13 || bus.imem_req !== 1'b1 || bus.inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: pc=%0d req=%b valid=%b expected 13 1 0", pc, bus.imem_req, bus.inst_valid);
    end
  endtask

  task automatic test_redirect();
    goto_pc(6'd5, 1'b1);
    redirect = 1'b1; redirect_addr = 6'h20;
    @(negedge clk);
    redirect = 1'b0;
    n_checks++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_drop: valid got %b expected 0", bus.inst_valid); end
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 6'h20) begin
      n_fail++; $display("FAIL redir_addr: req=%b addr=%h expected 1 20", bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 6'h20 || bus.inst_data !== 32'h1000_0020) begin
      n_fail++; $display("FAIL redir_fetch: valid=%b pc=%h data=%h expected 1 20 10000020", bus.inst_valid, bus.inst_pc, bus.inst_data);
    end
  endtask

  task automatic test_timeout();
    int cnt;
    goto_pc(6'd9, 1'b0);
    cnt = 0;
    while (bus.imem_req === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    n_checks++; if (cnt !== 15) begin n_fail++; $display("FAIL to_cycles: got %0d expected 15", cnt); end
    n_checks++; if (err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL to_flag: err=%b busy=%b expected 1 0", err, busy); end
    n_checks++; if (pc !== 6'd9) begin n_fail++; $display("FAIL to_pc: got %0d expected 9", pc); end
    @(negedge clk);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b expected 1", err); end
    mem_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (err !== 1'b0 || busy !== 1'b1 || bus.imem_req !== 1'b1 || bus.imem_addr !== 6'd9) begin
      n_fail++; $display("FAIL to_restart: err=%b busy=%b req=%b addr=%0d expected 0 1 1 9", err, busy, bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 6'd9) begin
      n_fail++; $display("FAIL to_refetch: valid=%b pc=%0d expected 1 9", bus.inst_valid, bus.inst_pc);
    end
  endtask

  task automatic test_halt_and_async_reset();
    goto_pc(6'd4, 1'b1);
    inc = 6'd2; halt = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 6'd4) begin
      n_fail++; $display("FAIL halt_fetch: valid=%b pc=%0d expected 1 4", bus.inst_valid, bus.inst_pc);
    end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || pc !== 6'd6 || bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL halt_idle: busy=%b pc=%0d req=%b valid=%b expected 0 6 0 0", busy, pc, bus.imem_req, bus.inst_valid);
    end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || bus.imem_req !== 1'b0) begin
      n_fail++; $display("FAIL halt_stay: busy=%b req=%b expected 0 0", busy, bus.imem_req);
    end
    halt = 1'b0; start = 1'b1; mem_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 6'd6) begin
      n_fail++; $display("FAIL halt_resume: req=%b addr=%0d expected 1 6", bus.imem_req, bus.imem_addr);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.imem_req !== 1'b0 || pc !== 6'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL async_rst: req=%b pc=%0d busy=%b expected 0 0 0", bus.imem_req, pc, busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wrap();
    test_stall();
    test_redirect();
    test_timeout();
    test_halt_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
